bot_velocity_sync_scheduler: RTL and testbench

Synthesizable scheduler that replaces per-bot polling of the robot-synchronisation loop. Every PERIOD cycles it snapshots reflection requests from N_BOTS bots and serves them one at a time, round-robin, on a single shared velocity write-back channel. For each served bot it negates the stored (vx, vy), sends the new pair on a valid/ready channel, and pulses that bot's acknowledge. It holds the per-bot velocity register file, which software loads through a config port.

---
 rtl/bot_velocity_sync_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_bot_velocity_sync_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_velocity_sync_scheduler.sv
// bot_velocity_sync_scheduler
//
// Purpose: every PERIOD cycles, snapshot the bots' reflection requests and
// serve them one at a time, round-robin, on one shared write-back channel.
// Serving a bot negates its stored (vx, vy) with saturation, presents the new
// pair on the write-back channel, then pulses that bot's ack for one cycle.
// Software loads the per-bot velocity register file through the cfg port,
// which only accepts writes while the scheduler is idle.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req[N_BOTS]     level reflection request per bot, sampled once per tick
//   ack[N_BOTS]     one-cycle pulse: bot i velocity has been updated
//   cfg_we/idx/vx/vy  velocity load strobe, target bot and values
//   cfg_ready       high while idle; cfg_we is ignored otherwise
//   wr_valid/ready  write-back handshake
//   wr_idx/vx/vy    write-back payload (bot index, negated velocity)
//   busy            scheduler is not idle
//   overrun_cnt     saturating count of ticks dropped while busy
//   dbg_state       current FSM state, for observation only
//
// Write-back handshake: the payload is held stable while wr_valid=1, and
// wr_valid stays high until a cycle in which wr_ready=1; the transfer happens
// on that rising edge. wr_ready seen while wr_valid=0 has no effect.
module bot_velocity_sync_scheduler #(
  parameter int N_BOTS = 3,
  parameter int VW     = 16,
  parameter int PERIOD = 300,
  parameter int IW     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BOTS-1:0] req,
  output logic [N_BOTS-1:0] ack,
  input  logic              cfg_we,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [VW-1:0]     cfg_vx,
  input  logic [VW-1:0]     cfg_vy,
  output logic              cfg_ready,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [IW-1:0]     wr_idx,
  output logic [VW-1:0]     wr_vx,
  output logic [VW-1:0]     wr_vy,
  output logic              busy,
  output logic [7:0]        overrun_cnt,
  output logic [2:0]        dbg_state
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0]     CNT_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [IW:0]       NB_W     = (IW + 1)'(N_BOTS);
  localparam logic [IW-1:0]     IDX_LAST = IW'(N_BOTS - 1);
  localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
  localparam logic [N_BOTS-1:0] ONE_N    = N_BOTS'(1);
  localparam logic [VW-1:0]     V_MIN    = {1'b1, {(VW-1){1'b0}}};
  localparam logic [VW-1:0]     V_MAX    = {1'b0, {(VW-1){1'b1}}};
  localparam logic [VW-1:0]     V_ONE    = VW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ARB   = 3'd2,
    S_UPD   = 3'd3,
    S_WRITE = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     sel_q;
  logic [N_BOTS-1:0] pend_q;
  logic [VW-1:0]     vx_q [N_BOTS];
  logic [VW-1:0]     vy_q [N_BOTS];
  logic [IW-1:0]     wr_idx_q;
  logic [VW-1:0]     wr_vx_q;
  logic [VW-1:0]     wr_vy_q;
  logic [7:0]        ovr_q;

  logic              tick;
  logic              cfg_hit;
  logic [N_BOTS-1:0] sel_oh;
  logic [VW-1:0]     nvx;
  logic [VW-1:0]     nvy;
  logic              arb_found;
  logic [IW-1:0]     arb_sel;
  logic [IW:0]       arb_pos;

  // Negating the most negative value would overflow; clamp it to the
  // most positive value instead.
  function automatic logic [VW-1:0] sat_neg(input logic [VW-1:0] x);
    if (x == V_MIN) begin
      return V_MAX;
    end
    return (~x) + V_ONE;
  endfunction

  assign tick    = (cnt_q == CNT_LAST);
  assign cfg_hit = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_idx} < NB_W);
  assign sel_oh  = ONE_N << sel_q;
  assign nvx     = sat_neg(vx_q[sel_q]);
  assign nvy     = sat_neg(vy_q[sel_q]);

  // Round-robin pick: first pending bit at ptr, ptr+1, ... wrapping at N_BOTS.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_pos   = '0;
    for (int k = 0; k < N_BOTS; k++) begin
      arb_pos = {1'b0, ptr_q} + (IW + 1)'(k);
      if (arb_pos >= NB_W) begin
        arb_pos = arb_pos - NB_W;
      end
      if (!arb_found && pend_q[arb_pos[IW-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = arb_pos[IW-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_d   = state_q;
    ack       = '0;
    wr_valid  = 1'b0;
    busy      = 1'b1;
    cfg_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        if (tick) state_d = S_SCAN;
      end
      S_SCAN:  state_d = (req == '0) ? S_IDLE : S_ARB;
      S_ARB:   state_d = S_UPD;
      S_UPD:   state_d = S_WRITE;
      S_WRITE: begin
        wr_valid = 1'b1;
        if (wr_ready) state_d = S_ACK;
      end
      S_ACK: begin
        ack     = sel_oh;
        state_d = ((pend_q & ~sel_oh) != '0) ? S_ARB : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Period counter, overrun counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      ptr_q    <= '0;
      sel_q    <= '0;
      pend_q   <= '0;
      wr_idx_q <= '0;
      wr_vx_q  <= '0;
      wr_vy_q  <= '0;
      ovr_q    <= '0;
      for (int i = 0; i < N_BOTS; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CNT_ONE;
      // A tick that arrives while a batch is still running is lost.
      if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (cfg_hit) begin
            vx_q[cfg_idx] <= cfg_vx;
            vy_q[cfg_idx] <= cfg_vy;
          end
        end
        S_SCAN: pend_q <= req;
        S_ARB:  sel_q  <= arb_sel;
        S_UPD: begin
          vx_q[sel_q] <= nvx;
          vy_q[sel_q] <= nvy;
          // The payload is captured here so it stays frozen through WRITE.
          wr_idx_q <= sel_q;
          wr_vx_q  <= nvx;
          wr_vy_q  <= nvy;
        end
        S_ACK: begin
          pend_q <= pend_q & ~sel_oh;
          ptr_q  <= (sel_q == IDX_LAST) ? '0 : sel_q + IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  assign wr_idx      = wr_idx_q;
  assign wr_vx       = wr_vx_q;
  assign wr_vy       = wr_vy_q;
  assign overrun_cnt = ovr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bot_velocity_sync_scheduler.sv
module tb_bot_velocity_sync_scheduler;

  localparam int N  = 3;
  localparam int VW = 16;
  localparam int P  = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- DUT ----------------
  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [VW-1:0] cfg_vx, cfg_vy;
  logic          cfg_ready;
  logic          wr_valid, wr_ready;
  logic [IW-1:0] wr_idx;
  logic [VW-1:0] wr_vx, wr_vy;
  logic          busy;
  logic [7:0]    overrun_cnt;
  logic [2:0]    dbg_state;

  bot_velocity_sync_scheduler #(.N_BOTS(N), .VW(VW), .PERIOD(P), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .cfg_ready(cfg_ready), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_vx(wr_vx), .wr_vy(wr_vy), .busy(busy),
    .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [VW-1:0] mvx [N];
  logic [VW-1:0] mvy [N];
  int            mptr;
  int            movr;
  bit            act;
  int            t0, nb, ws, ack_c, last_bot, nbatch;
  logic [IW-1:0] exp_q [$];   // remaining grant order of the current batch
  int            srv_q [$];   // bots actually granted (from DUT)
  int            hs_c, hs_idx;
  logic [VW-1:0] hs_vx, hs_vy;

  // next-cycle input drive
  logic [N-1:0]  drv_mask;
  logic          drv_rdy, drv_we;
  logic [IW-1:0] drv_idx;
  logic [VW-1:0] drv_vx, drv_vy;
  int            rdy_hold_until;

  function automatic logic [VW-1:0] neg_sat(input logic [VW-1:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return v[VW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, a, e);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timeout cyc=%0d dbg_state=%0d", nm, cyc, dbg_state);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mvx[i] = '0;
      mvy[i] = '0;
    end
    mptr = 0; movr = 0; act = 0; nb = 0; t0 = -100; ws = 0;
    ack_c = -100; last_bot = 0;
    exp_q.delete();
  endtask

  task automatic chk_outputs_reset(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_wr_idx"}, wr_idx, 0);
    chk({tag, "_wr_vx"}, wr_vx, 0);
    chk({tag, "_wr_vy"}, wr_vy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_overrun"}, overrun_cnt, 0);
  endtask

  // One clock: compare outputs against the model, drive inputs, advance model.
  task automatic cycle();
    int            c;
    bit            tck, busy_e, ev, rdy;
    logic [N-1:0]  ea;
    logic [IW-1:0] b;
    @(posedge clk);
    #1;
    c   = cyc;
    tck = (c % P) == (P - 1);
    busy_e = 1'b0;
    if (act) begin
      if (nb == 0) busy_e = (c == t0 + 1);
      else         busy_e = (c > t0) && !(exp_q.size() == 0 && c > ack_c);
    end
    ev = act && (exp_q.size() != 0) && (c >= ws);
    ea = '0;
    if (c == ack_c) ea[last_bot] = 1'b1;
    chk("busy", busy, busy_e);
    chk("cfg_ready", cfg_ready, !busy_e);
    chk("wr_valid", wr_valid, ev);
    chk("ack", ack, ea);
    chk("overrun_cnt", overrun_cnt, movr);
    if (ev) begin
      b = exp_q[0];
      chk("wr_idx", wr_idx, b);
      chk("wr_vx", wr_vx, neg_sat(mvx[b]));
      chk("wr_vy", wr_vy, neg_sat(mvy[b]));
    end
    if (act && c > t0 && !busy_e) act = 0;

    rdy      = drv_rdy && (c >= rdy_hold_until);
    wr_ready = rdy;
    cfg_we   = drv_we;
    cfg_idx  = drv_idx;
    cfg_vx   = drv_vx;
    cfg_vy   = drv_vy;
    if (c == ack_c) req[last_bot] = 1'b0;

    if (drv_we && !busy_e && drv_idx < N) begin
      mvx[drv_idx] = drv_vx;
      mvy[drv_idx] = drv_vy;
    end
    if (tck) begin
      if (busy_e) begin
        if (movr < 255) movr++;
      end else begin
        req = drv_mask;
        act = 1; t0 = c; nb = 0; ws = c + 4;
        exp_q.delete();
        for (int k = 0; k < N; k++) begin
          int bb;
          bb = (mptr + k) % N;
          if (req[bb]) begin
            exp_q.push_back(IW'(bb));
            nb++;
          end
        end
        if (nb > 0) mptr = (int'(exp_q[nb-1]) + 1) % N;
        nbatch++;
      end
    end
    if (ev && rdy) begin
      b = exp_q.pop_front();
      hs_c = c; hs_idx = int'(wr_idx); hs_vx = wr_vx; hs_vy = wr_vy;
      srv_q.push_back(int'(wr_idx));
      mvx[b] = neg_sat(mvx[b]);
      mvy[b] = neg_sat(mvy[b]);
      ack_c = c + 1; last_bot = b; ws = c + 4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input int bot, input logic [VW-1:0] vx, input logic [VW-1:0] vy);
    drv_we = 1; drv_idx = IW'(bot); drv_vx = vx; drv_vy = vy;
    cycle();
    drv_we = 0;
  endtask

  // Present mask at the next idle tick and run the batch to completion.
  task automatic batch(input logic [N-1:0] mask, input bit busy_we, input int stall);
    int nb0, k, ovr0;
    nb0 = nbatch; drv_mask = mask; drv_we = 0; drv_rdy = 1;
    k = 0;
    while (nbatch == nb0 && k < 4 * P) begin
      cycle();
      k++;
    end
    drv_mask = '0;
    if (nbatch == nb0) begin
      timeout_fail("batch_start");
      return;
    end
    srv_q.delete();
    ovr0 = movr;
    rdy_hold_until = (stall > 0) ? t0 + 4 + stall : 0;
    drv_we = busy_we; drv_idx = 1; drv_vx = 16'h5A5A; drv_vy = 16'hA5A5;
    k = 0;
    while (act && k < 300) begin
      if (exp_q.size() == 0) drv_we = 0;
      cycle();
      if (stall > 0 && cyc == t0 + 4 + stall) chk("ovr_stall", overrun_cnt, ovr0 + 2);
      k++;
    end
    drv_we = 0; rdy_hold_until = 0;
    if (act) timeout_fail("batch_done");
  endtask

  function automatic int order_code();
    int code;
    code = 0;
    foreach (srv_q[i]) code = code * 10 + srv_q[i] + 1;
    return code;
  endfunction

  // ---------------- test ----------------
  typedef struct {
    int            bot;
    logic [VW-1:0] vx, vy, evx, evy;
  } vec_t;
  vec_t tbl [5];

  initial begin
    int nb0, k;
    tbl[0] = '{1, 16'h0003, 16'h0004, 16'hFFFD, 16'hFFFC};
    tbl[1] = '{0, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8001};
    tbl[2] = '{2, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF};
    tbl[3] = '{1, 16'hFFFD, 16'hFFFC, 16'h0003, 16'h0004};
    tbl[4] = '{2, 16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF};

    rst = 1; req = '0; cfg_we = 0; cfg_idx = '0; cfg_vx = '0; cfg_vy = '0; wr_ready = 0;
    drv_mask = '0; drv_rdy = 1; drv_we = 0; drv_idx = '0; drv_vx = '0; drv_vy = '0;
    rdy_hold_until = 0; nbatch = 0; hs_c = 0; hs_idx = 0; hs_vx = '0; hs_vy = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_reset("reset");
    rst = 0;

    // table-driven single-bot reflections
    for (int i = 0; i < 5; i++) begin
      load(tbl[i].bot, tbl[i].vx, tbl[i].vy);
      batch(N'(1) << tbl[i].bot, 0, 0);
      chk("tbl_idx", hs_idx, tbl[i].bot);
      chk("tbl_vx", hs_vx, tbl[i].evx);
      chk("tbl_vy", hs_vy, tbl[i].evy);
      chk("tbl_latency", hs_c - t0, 4);
    end

    // round-robin order, busy cfg ignored, out-of-range cfg ignored
    load(0, 16'h0100, 16'h0011);
    load(1, 16'h0200, 16'h0022);
    load(2, 16'h0300, 16'h0033);
    load(3, 16'h7777, 16'h7777);
    batch(3'b111, 1, 0);
    chk("order_all", order_code(), 123);
    batch(3'b101, 0, 0);
    chk("order_0_2", order_code(), 13);
    batch(3'b001, 0, 0);
    chk("order_0a", order_code(), 1);
    batch(3'b001, 0, 0);
    chk("order_0_wrap", order_code(), 1);

    // 20-cycle write-back stall
    batch(3'b010, 0, 20);
    chk("stall_hs", hs_c - t0, 24);

    // reset while wr_valid is high
    nb0 = nbatch; drv_mask = 3'b100; k = 0;
    while (nbatch == nb0 && k < 4 * P) begin
      cycle();
      k++;
    end
    drv_mask = '0;
    if (nbatch == nb0) timeout_fail("rst_batch_start");
    rdy_hold_until = t0 + 1000;
    repeat (5) cycle();
    chk("pre_rst_valid", wr_valid, 1);
    #2 rst = 1;
    #1;
    chk_outputs_reset("async_rst");
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    model_reset();
    rdy_hold_until = 0;
    batch(3'b011, 0, 0);
    chk("first_tick", t0, P - 1);
    chk("post_rst_vx", hs_vx, 0);
    chk("post_rst_vy", hs_vy, 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      drv_mask = N'($urandom_range(0, 7));
      drv_rdy  = ($urandom_range(0, 3) != 0);
      drv_we   = ($urandom_range(0, 4) == 0);
      drv_idx  = IW'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       drv_vx = 16'h8000;
        1:       drv_vx = 16'h7FFF;
        default: drv_vx = VW'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       drv_vy = 16'h8000;
        1:       drv_vy = 16'h0000;
        default: drv_vy = VW'($urandom);
      endcase
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
